// File: rtl/conv_blk_stager_if.sv
// conv_blk_stager_if
// Groups the two stager buses into one interface.
//   Upstream byte bus  : in_data, in_valid, in_sof, in_size -> stager; in_ready <- stager
//   Encoder read bus   : blk_ready, blk_meta, blk_empty, blk_data <- stager;
//                        blk_meta_rdreq, blk_data_rdreq -> stager
// slave  : the stager's view.
// master : the view of the environment (segmentation stage + encoder).
interface conv_blk_stager_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       in_size;
    logic       in_ready;

    logic       blk_ready;
    logic [7:0] blk_meta;
    logic       blk_empty;
    logic [7:0] blk_data;
    logic       blk_meta_rdreq;
    logic       blk_data_rdreq;

    modport slave (
        input  in_data, in_valid, in_sof, in_size,
        output in_ready,
        output blk_ready, blk_meta, blk_empty, blk_data,
        input  blk_meta_rdreq, blk_data_rdreq
    );

    modport master (
        output in_data, in_valid, in_sof, in_size,
        input  in_ready,
        input  blk_ready, blk_meta, blk_empty, blk_data,
        output blk_meta_rdreq, blk_data_rdreq
    );
endinterface

// File: rtl/conv_blk_stager.sv
// conv_blk_stager
// Two-bank ping-pong byte buffer in front of the convolutional encoder.
// The upstream stage fills one bank with a whole code block (132 or 768
// bytes) while the encoder drains the other through a meta word
// {tail[5:0], 1'b0, size} and a show-ahead byte stream.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - conv_blk_stager_if.slave (upstream byte bus + encoder read bus)
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for in_sof; the write bank is free
//   W_FILL | storing bytes of the current block into the write bank
//   W_FULL | both banks committed; in_ready low until a bank is released
module conv_blk_stager #(
    parameter int SMALL_BYTES = 132,
    parameter int LARGE_BYTES = 768
) (
    input  logic           clk,
    input  logic           reset,
    conv_blk_stager_if.slave bus
);
    localparam int CW = $clog2(LARGE_BYTES + 1);
    localparam logic [CW-1:0] SMALL_N = CW'(SMALL_BYTES);
    localparam logic [CW-1:0] LARGE_N = CW'(LARGE_BYTES);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_FULL = 2'd2;

    logic [1:0]    w_state;
    logic          wr_bank;
    logic          wr_size;
    logic [CW-1:0] wr_cnt;

    logic          rd_bank;
    logic [CW-1:0] rd_cnt;

    logic [1:0]    committed;
    logic [1:0]    meta_taken;
    logic [1:0]    bank_size;
    logic [5:0]    bank_tail [2];

    logic [7:0]    mem [2][LARGE_BYTES];
    logic [7:0]    rd_data;

    logic          accept;
    logic          sof_start;
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic          new_size;
    logic [CW-1:0] wr_target;
    logic          commit;
    logic          pop;
    logic [CW-1:0] rd_last;
    logic          release_bank;
    logic          other_free;
    logic          rd_bank_nxt;
    logic [CW-1:0] rd_cnt_nxt;

    always_comb begin
        accept       = bus.in_valid && (w_state != W_FULL);
        // A new block may start from W_IDLE, or restart mid-fill on in_sof.
        sof_start    = accept && bus.in_sof &&
                       ((w_state == W_FILL) || !committed[wr_bank]);
        wr_en        = sof_start || (accept && (w_state == W_FILL));
        wr_addr      = sof_start ? '0 : wr_cnt;
        new_size     = sof_start ? bus.in_size : wr_size;
        wr_target    = new_size ? LARGE_N : SMALL_N;
        commit       = wr_en && ((wr_addr + ONE) == wr_target);

        pop          = bus.blk_data_rdreq && committed[rd_bank];
        rd_last      = (bank_size[rd_bank] ? LARGE_N : SMALL_N) - ONE;
        release_bank = pop && (rd_cnt == rd_last);
        // A bank released in the same cycle counts as free, so a commit that
        // coincides with a release goes straight back to W_IDLE.
        other_free   = !committed[~wr_bank] ||
                       (release_bank && (rd_bank == ~wr_bank));

        rd_bank_nxt  = release_bank ? ~rd_bank : rd_bank;
        rd_cnt_nxt   = release_bank ? '0 : (pop ? rd_cnt + ONE : rd_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            wr_bank <= 1'b0;
            wr_size <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (wr_en) wr_cnt <= wr_addr + ONE;
            if (sof_start) wr_size <= bus.in_size;
            case (w_state)
                W_IDLE: if (sof_start) w_state <= W_FILL;
                W_FILL: begin
                    if (commit) begin
                        wr_bank <= ~wr_bank;
                        w_state <= other_free ? W_IDLE : W_FULL;
                    end
                end
                W_FULL: if (release_bank) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bank      <= 1'b0;
            rd_cnt       <= '0;
            committed    <= '0;
            meta_taken   <= '0;
            bank_size    <= '0;
            bank_tail[0] <= '0;
            bank_tail[1] <= '0;
        end else begin
            rd_bank <= rd_bank_nxt;
            rd_cnt  <= rd_cnt_nxt;
            if (bus.blk_meta_rdreq && committed[rd_bank] && !meta_taken[rd_bank])
                meta_taken[rd_bank] <= 1'b1;
            if (release_bank) begin
                committed[rd_bank]  <= 1'b0;
                meta_taken[rd_bank] <= 1'b0;
            end
            // commit and release always target different banks
            if (commit) begin
                committed[wr_bank]  <= 1'b1;
                meta_taken[wr_bank] <= 1'b0;
                bank_size[wr_bank]  <= new_size;
                bank_tail[wr_bank]  <= bus.in_data[7:2];
            end
        end
    end

    // The read port fetches the byte that will be at the head next cycle,
    // so blk_data is valid the cycle after a commit and under back-to-back
    // pops. It never collides with a write: the bank being filled is only
    // read once committed, and its byte 0 was written earlier.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_addr] <= bus.in_data;
        rd_data <= mem[rd_bank_nxt][rd_cnt_nxt];
    end

    assign bus.in_ready  = (w_state != W_FULL);
    assign bus.blk_ready = committed[rd_bank];
    assign bus.blk_empty = !committed[rd_bank];
    assign bus.blk_meta  = committed[rd_bank] ?
                           {bank_tail[rd_bank], 1'b0, bank_size[rd_bank]} : 8'h00;
    assign bus.blk_data  = committed[rd_bank] ? rd_data : 8'h00;
endmodule

// File: tb/tb_conv_blk_stager.sv
// tb_conv_blk_stager
// Drives conv_blk_stager with random and directed code blocks and checks the
// encoder-side stream against a queue model of committed blocks.
module tb_conv_blk_stager;
    localparam int SB = 132;
    localparam int LB = 768;

    logic clk = 1'b0;
    logic reset = 1'b1;
    conv_blk_stager_if bus ();

    conv_blk_stager #(.SMALL_BYTES(SB), .LARGE_BYTES(LB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    bit hung = 0;

    logic [7:0] exp_data [$];
    logic [7:0] exp_meta [$];
    int         exp_len  [$];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic sof, input logic sz);
        int t = 0;
        if (hung) return;
        bus.in_valid = 1'b0;
        while (bus.in_ready !== 1'b1) begin
            if (t >= 5000) begin
                errs++; hung = 1;
                $display("FAIL send_timeout: in_ready=%b want 1", bus.in_ready);
                return;
            end
            @(negedge clk); t++;
        end
        bus.in_data = d; bus.in_sof = sof; bus.in_size = sz; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    endtask

    // Sends restart_at junk bytes (discarded by a following in_sof), then a
    // full block; only the full block enters the model.
    task automatic send_block(input logic sz, input int restart_at, input bit ramp,
                              input bit fix_last, input logic [7:0] last_val);
        int n;
        logic [7:0] blk [$];
        logic [7:0] b;
        n = sz ? LB : SB;
        for (int i = 0; i < restart_at; i++) send_byte(8'($urandom), i == 0, sz);
        blk = {};
        for (int i = 0; i < n; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            if (fix_last && i == n - 1) b = last_val;
            blk.push_back(b);
            exp_data.push_back(b);
        end
        b = blk[n-1];
        exp_len.push_back(n);
        exp_meta.push_back({b[7:2], 1'b0, sz});
        for (int i = 0; i < n; i++) send_byte(blk[i], i == 0, sz);
    endtask

    task automatic drain_blocks(input int nblk);
        int done_blk = 0;
        int pos = 0;
        int t = 0;
        while (done_blk < nblk) begin
            if (t >= 20000) begin
                errs++;
                $display("FAIL drain_timeout: %0d of %0d blocks read, want all", done_blk, nblk);
                break;
            end
            bus.blk_meta_rdreq = 1'($urandom_range(1));
            if (bus.blk_empty === 1'b0) begin
                if (exp_data.size() == 0) begin
                    errs++;
                    $display("FAIL drain_unexpected: blk_empty=0 want 1 (no block expected)");
                    break;
                end
                vecs++;
                if (bus.blk_data !== exp_data[0]) begin
                    errs++;
                    $display("FAIL drain_data: blk_data=%h want %h (byte %0d)", bus.blk_data, exp_data[0], pos);
                end
                vecs++;
                if (bus.blk_meta !== exp_meta[0]) begin
                    errs++;
                    $display("FAIL drain_meta: blk_meta=%h want %h", bus.blk_meta, exp_meta[0]);
                end
                if ($urandom_range(3) != 0) begin
                    bus.blk_data_rdreq = 1'b1;
                    void'(exp_data.pop_front());
                    pos++;
                    if (pos == exp_len[0]) begin
                        pos = 0;
                        void'(exp_len.pop_front());
                        void'(exp_meta.pop_front());
                        done_blk++;
                    end
                end else begin
                    bus.blk_data_rdreq = 1'b0;
                end
            end else begin
                // pops while empty must be ignored
                bus.blk_data_rdreq = 1'($urandom_range(1));
            end
            @(negedge clk); t++;
        end
        bus.blk_data_rdreq = 1'b0;
        bus.blk_meta_rdreq = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        vecs++;
        if (bus.blk_empty !== 1'b1 || bus.blk_ready !== 1'b0) begin
            errs++;
            $display("FAIL %s_idle: empty=%b ready=%b want empty=1 ready=0", tag, bus.blk_empty, bus.blk_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vecs++;
        if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL %s_in_ready: %b want 1", tag, bus.in_ready); end
        vecs++;
        if (bus.blk_ready !== 1'b0) begin errs++; $display("FAIL %s_blk_ready: %b want 0", tag, bus.blk_ready); end
        vecs++;
        if (bus.blk_empty !== 1'b1) begin errs++; $display("FAIL %s_blk_empty: %b want 1", tag, bus.blk_empty); end
        vecs++;
        if (bus.blk_meta !== 8'h00) begin errs++; $display("FAIL %s_blk_meta: %h want 00", tag, bus.blk_meta); end
        vecs++;
        if (bus.blk_data !== 8'h00) begin errs++; $display("FAIL %s_blk_data: %h want 00", tag, bus.blk_data); end
    endtask

    task automatic test_reset();
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_size = 1'b0;
        bus.blk_meta_rdreq = 1'b0; bus.blk_data_rdreq = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");
    endtask

    task automatic test_small_ramp();
        send_block(1'b0, 0, 1'b1, 1'b0, 8'h00);
        vecs++;
        if (bus.blk_ready !== 1'b1) begin errs++; $display("FAIL small_latency: blk_ready=%b want 1", bus.blk_ready); end
        vecs++;
        if (bus.blk_meta !== 8'h80) begin errs++; $display("FAIL small_meta: %h want 80", bus.blk_meta); end
        vecs++;
        if (bus.blk_data !== 8'h00) begin errs++; $display("FAIL small_byte0: %h want 00", bus.blk_data); end
        drain_blocks(1);
        check_idle("small");
    endtask

    task automatic test_large();
        send_block(1'b1, 0, 1'b0, 1'b1, 8'hFC);
        vecs++;
        if (bus.blk_meta !== 8'hFD) begin errs++; $display("FAIL large_meta: %h want fd", bus.blk_meta); end
        drain_blocks(1);
        check_idle("large");
    endtask

    task automatic test_stall();
        send_block(1'b0, 0, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL stall_ready_after_1st: %b want 1", bus.in_ready); end
        send_block(1'b0, 0, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL stall_ready_after_264: %b want 0", bus.in_ready); end
        repeat (5) @(negedge clk);
        vecs++;
        if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL stall_ready_held: %b want 0", bus.in_ready); end
        drain_blocks(1);
        vecs++;
        if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL stall_ready_release: %b want 1", bus.in_ready); end
        vecs++;
        if (bus.blk_ready !== 1'b1) begin errs++; $display("FAIL stall_next_ready: %b want 1", bus.blk_ready); end
        send_block(1'b0, 0, 1'b0, 1'b0, 8'h00);
        drain_blocks(2);
        check_idle("stall");
    endtask

    task automatic test_restart();
        send_block(1'b1, 50, 1'b0, 1'b1, 8'h5A);
        vecs++;
        if (bus.blk_meta !== 8'h59) begin errs++; $display("FAIL restart_meta: %h want 59", bus.blk_meta); end
        drain_blocks(1);
        check_idle("restart");
    endtask

    task automatic test_rdreq_empty();
        bus.blk_data_rdreq = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("rdreq_empty_pre");
        send_block(1'b0, 0, 1'b0, 1'b0, 8'h00);
        vecs++;
        if (bus.blk_empty !== 1'b0 || bus.blk_data !== exp_data[0]) begin
            errs++;
            $display("FAIL rdreq_empty_byte0: empty=%b data=%h want empty=0 data=%h", bus.blk_empty, bus.blk_data, exp_data[0]);
        end
        void'(exp_data.pop_front());
        @(negedge clk);
        vecs++;
        if (bus.blk_data !== exp_data[0]) begin
            errs++;
            $display("FAIL rdreq_empty_byte1: %h want %h", bus.blk_data, exp_data[0]);
        end
        bus.blk_data_rdreq = 1'b0;
        exp_len[0] = exp_len[0] - 1;
        drain_blocks(1);
        check_idle("rdreq_empty");
    endtask

    task automatic test_mid_reset();
        send_block(1'b0, 0, 1'b0, 1'b0, 8'h00);
        bus.blk_data_rdreq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vecs++;
            if (bus.blk_data !== exp_data[0]) begin
                errs++;
                $display("FAIL midreset_pop: %h want %h (byte %0d)", bus.blk_data, exp_data[0], i);
            end
            void'(exp_data.pop_front());
            @(negedge clk);
        end
        bus.blk_data_rdreq = 1'b0;
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), i == 0, 1'b0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        exp_data.delete(); exp_meta.delete(); exp_len.delete();
        @(negedge clk);
        check_reset_outputs("midreset_after");
        send_block(1'($urandom_range(1)), 0, 1'b0, 1'b0, 8'h00);
        drain_blocks(1);
        check_idle("midreset");
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_block(1'($urandom_range(1)),
                               ($urandom_range(3) == 0) ? int'($urandom_range(100, 1)) : 0,
                               1'b0, 1'b0, 8'h00);
            end
            begin
                drain_blocks(6);
            end
        join
        check_idle("b2b");
        vecs++;
        if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready: %b want 1", bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_small_ramp();
        test_large();
        test_stall();
        test_restart();
        test_rdreq_empty();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/conv_blk_stager.md
Name: conv_blk_stager

Overview:
- Ping-pong byte buffer directly upstream of the convolutional encoder.
- Collects one code block (1056-bit small or 6144-bit large, LSB-first within each byte) from the segmentation stage.
- Extracts the six tail bits needed for tail-biting state initialisation and presents the block to the encoder through a meta word plus a show-ahead byte stream.
- Two banks let the upstream stage fill one block while the encoder drains the other.

Parameters:
- SMALL_BYTES, 132, byte count of a small block (1056 bits).
- LARGE_BYTES, 768, byte count of a large block (6144 bits); also the depth of each bank.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  upstream byte; bit i is block bit 8n+i.
- in_valid  in  1  in_data valid this cycle.
- in_sof  in  1  first byte of a block; qualified by in_valid.
- in_size  in  1  block size, sampled with in_sof: 0 = small, 1 = large.
- in_ready  out  1  stager accepts a byte this cycle.
- blk_ready  out  1  at least one complete block is committed and not yet fully read.
- blk_meta  out  8  {tail[5:0], 1'b0, size} of the head block; tail = last byte bits [7:2].
- blk_empty  out  1  no committed byte is available to read.
- blk_data  out  8  show-ahead head byte of the head block.
- blk_meta_rdreq  in  1  consume the meta word of the head block.
- blk_data_rdreq  in  1  pop the head byte.

Behaviour:
- Reset (async) values: in_ready=1, blk_ready=0, blk_empty=1, blk_meta=0, blk_data=0. Both banks free; write/read bank pointers = 0; all counters = 0.
- Write FSM states: W_IDLE, W_FILL, W_FULL.
  - W_IDLE: in_valid & in_sof & free bank present → store byte at address 0, latch size, count=1, go to W_FILL.
  - In W_IDLE, bytes with in_valid and no in_sof are dropped.
  - W_FILL: each in_valid byte is stored at address count, count+1.
  - When count reaches SMALL_BYTES or LARGE_BYTES (per latched size): latch last byte[7:2] as tail, commit bank, toggle write pointer.
  - After commit: go to W_IDLE if the other bank is free, else W_FULL.
  - in_sof during W_FILL: partial block is discarded; the sof byte starts a new block in the same bank at address 0.
  - W_FULL: in_ready=0. Go to W_IDLE the cycle after a bank is released.
- in_ready = 1 in W_IDLE/W_FILL, 0 in W_FULL. Bytes with in_valid & !in_ready are lost; the sender must honour in_ready.
- Commit-to-read latency: blk_ready and blk_empty=0 assert the cycle after the final byte is written. blk_data shows byte 0 in that same cycle.
- Read side, per bank: meta_taken flag and a read address rd_cnt.
  - blk_meta is valid whenever blk_ready=1.
  - blk_meta_rdreq sets meta_taken. A repeated blk_meta_rdreq is ignored.
  - blk_data_rdreq & !blk_empty: rd_cnt+1; the next byte appears on blk_data next cycle.
  - The RAM read is pipelined so show-ahead holds with no bubble under back-to-back pops.
  - Meta and data reads are independent; both may be asserted in the same cycle.
- Bank release: on the pop of the final byte (rd_cnt = size-1), the bank is freed and the read pointer toggles.
  - If the other bank is committed, blk_ready stays 1 and blk_meta/blk_data show the new block next cycle. Otherwise blk_ready=0 and blk_empty=1.
- blk_data_rdreq while blk_empty=1: ignored; no pointer change, no underflow.
- Simultaneous commit and release in the same cycle: both take effect. Exactly one bank is committed afterwards; no in_ready glitch.
- Size change between blocks is allowed; each bank carries its own size and tail.
- blk_meta[1] is always 0.

Test Plan:
- Small block, bytes 0x00..0x83 (last byte 0x83 = 1000_0011) → blk_ready 1 cycle after last write, blk_meta=8'b100000_00, blk_data=0x00. 132 pops return 0x00..0x83 in order, then blk_empty=1, blk_ready=0.
- Large block, last byte 0xFC, in_size=1 → blk_meta=0xFD; exactly 768 pops before blk_empty=1.
- Three small blocks streamed with the encoder stalled → in_ready drops after the 264th byte. First release re-raises in_ready one cycle later; third block's data is intact.
- in_sof reasserted at byte 50 of a large block → partial discarded; only the restarted block is presented, with the correct tail.
- blk_data_rdreq held high while empty, then a block commits → no pointer movement before commit; byte 0 is popped on the first cycle blk_empty=0.
- Reset asserted mid-read of bank 0 while bank 1 is filling → outputs return to reset values immediately (async). A subsequent block is presented from bank 0 correctly.
